scan_decoder: RTL and testbench
===============================

# scan_decoder

Parametrised registered 1-of-2^SEL_W decoder with active-low outputs and a three-input enable group: two active-low enables and one active-high enable. It adds an auto-scan mode that steps through a maskable set of channels with a programmable dwell time. It sits between control logic and multiplexed loads such as LED or 7-segment digit commons. It replaces hand-written 3-to-8 decoders.

## Interface
Parameters:
- SEL_W, 3, address width; channel count N = 2^SEL_W (valid 1..6)
- DWELL_W, 16, dwell counter width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- en1_n  in  1  active-low enable
- en2_n  in  1  active-low enable
- en3  in  1  active-high enable
- mode  in  1  0 = manual (decode sel), 1 = scan
- sel  in  SEL_W  manual channel address
- dwell  in  DWELL_W  scan hold time; each channel is held dwell+1 cycles
- mask  in  N  1 = channel included in scan; ignored in manual mode
- q_n  out  N  registered one-cold outputs; all ones when no channel is active
- cur  out  SEL_W  registered index of the current channel
- step  out  1  one-cycle pulse, registered, when scan advances

## Operation
- Internal enable: en = en3 & ~en1_n & ~en2_n, evaluated each cycle.
- Reset values while rst is high, asynchronous: q_n = all ones, cur = 0, dwell counter cnt = 0, step = 0.
- Manual mode (mode = 0):
  - cur <= sel every cycle, regardless of en.
  - q_n <= ~(1 << sel) when en = 1; all ones when en = 0.
  - cnt <= 0; step = 0.
- Scan mode (mode = 1), en = 1:
  - next = first index with mask set, searching cur+1, cur+2, … and wrapping through cur itself (modulo N).
  - If mask[cur] = 0 and mask ≠ 0: advance immediately to next (no dwell wait); cnt <= 0; step <= 1.
  - Else if cnt ≥ dwell: cur <= next; cnt <= 0; step <= 1.
  - Else: cnt <= cnt + 1; step <= 0.
  - If mask = 0: cur holds, cnt holds, step = 0, q_n = all ones.
  - q_n is driven from the updated cur: ~(1 << cur_next) when mask[cur_next] = 1, otherwise all ones.
  - Single-bit mask equal to cur: next = cur; step still pulses every dwell+1 cycles.
- Scan mode, en = 0: cur and cnt hold, q_n = all ones, step = 0. Scan resumes with the remaining dwell when en returns.
- Mode change manual→scan: scan starts from the current cur with cnt = 0 (cleared in manual mode). Mode change scan→manual takes effect on the next edge; sel is decoded.
- dwell changes take effect immediately. The ≥ comparison guarantees an advance on the next cycle if cnt already exceeds the new dwell.
- cnt never wraps: it is bounded by dwell ≤ 2^DWELL_W − 1.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Manual latency is 1 cycle: sel, en or mode sampled at edge k are visible on q_n and cur after edge k.
- Scan: a masked channel stays active for exactly dwell+1 enabled cycles. step is high for the first cycle the new cur is visible.
- With dwell = 0, scan advances every enabled cycle and step stays high continuously.
- Reset asserted mid-scan forces all outputs to reset values immediately. After release, the first edge behaves as after cold reset: manual decodes sel, scan starts at cur = 0.
- Simultaneous mask change and dwell expiry: the next-index search uses the mask value sampled on that edge.

## Test plan
- Manual decode: SEL_W = 3, en active, sel sweeps 0..7 → q_n = 8'b11111110, 11111101, …, 01111111, each one cycle after sel; cur tracks sel.
- Enable gating: en1_n = 1, or en2_n = 1, or en3 = 0, with sel = 5 → q_n = 8'hFF; restore enables → q_n = 8'b11011111 on the next edge.
- Scan with mask: mask = 8'b10100101, dwell = 2 → cur sequence 0,2,5,7,0,… each held 3 cycles; step pulses once per change; q_n is one-cold on the matching bit.
- Mask edge cases: mask = 0 → q_n = 8'hFF, step = 0, cur frozen. Clear mask[cur] mid-dwell → advance on the next edge with step = 1. Single-bit mask = 8'b00001000, dwell = 1 → cur stays 3; step pulses every 2 cycles.
- Enable pause: deassert en3 for 5 cycles mid-dwell (cnt = 1, dwell = 3) → q_n = all ones, cur held; after re-enable the channel completes its remaining 2 cycles.
- Reset mid-scan: assert rst asynchronously between edges with cur = 5 → q_n = all ones, cur = 0, step = 0 immediately; after release, scan restarts from the first masked index ≥ 0.

Source files
------------

// File: rtl/scan_decoder.sv
// Registered 1-of-2^SEL_W active-low decoder with a three-input enable group
// and an auto-scan mode that walks a maskable channel set with a programmable dwell.
module scan_decoder #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en1_n,
  input  logic                    en2_n,
  input  logic                    en3,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [DWELL_W-1:0]      dwell,
  input  logic [(1<<SEL_W)-1:0]   mask,
  output logic [(1<<SEL_W)-1:0]   q_n,
  output logic [SEL_W-1:0]        cur,
  output logic                    step
);
  localparam int N = 1 << SEL_W;
  localparam logic [N-1:0] ONE = N'(1);

  logic [N-1:0]       q_n_q, q_n_d;
  logic [SEL_W-1:0]   cur_q, cur_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               step_q, step_d;
  logic               en;
  logic [SEL_W-1:0]   nxt, idx;
  logic               found;

  assign en = en3 & ~en1_n & ~en2_n;

  // First masked channel after cur, wrapping round to cur itself last.
  always_comb begin
    nxt   = cur_q;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = cur_q + SEL_W'(k);
      if (!found && mask[idx]) begin
        nxt   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    cur_d  = cur_q;
    cnt_d  = cnt_q;
    step_d = 1'b0;
    q_n_d  = '1;
    if (!mode) begin
      cur_d = sel;
      cnt_d = '0;
      if (en) q_n_d = ~(ONE << sel);
    end else if (en && (|mask)) begin
      // A channel dropped from the mask is abandoned without waiting out its dwell.
      if (!mask[cur_q] || (cnt_q >= dwell)) begin
        cur_d  = nxt;
        cnt_d  = '0;
        step_d = 1'b1;
      end else begin
        cnt_d = cnt_q + DWELL_W'(1);
      end
      if (mask[cur_d]) q_n_d = ~(ONE << cur_d);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_n_q  <= '1;
      cur_q  <= '0;
      cnt_q  <= '0;
      step_q <= 1'b0;
    end else begin
      q_n_q  <= q_n_d;
      cur_q  <= cur_d;
      cnt_q  <= cnt_d;
      step_q <= step_d;
    end
  end

  assign q_n  = q_n_q;
  assign cur  = cur_q;
  assign step = step_q;

`ifndef SYNTHESIS
  a_one_cold: assert property (@(posedge clk) disable iff (rst) $onehot0(~q_n));
`endif
endmodule

// File: tb/tb_scan_decoder.sv
// Scoreboard bench for scan_decoder: the driver pushes reference-model expectations,
// the monitor pops one per clock edge and compares against the registered outputs.
module tb_scan_decoder;
  localparam int SEL_W = 3;
  localparam int DWELL_W = 16;
  localparam int N = 1 << SEL_W;

  logic clk = 1'b0;
  logic rst, en1_n, en2_n, en3, mode;
  logic [SEL_W-1:0] sel;
  logic [DWELL_W-1:0] dwell;
  logic [N-1:0] mask;
  logic [N-1:0] q_n;
  logic [SEL_W-1:0] cur;
  logic step;

  scan_decoder #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
    .clk(clk), .rst(rst), .en1_n(en1_n), .en2_n(en2_n), .en3(en3), .mode(mode),
    .sel(sel), .dwell(dwell), .mask(mask), .q_n(q_n), .cur(cur), .step(step)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]     qn;
    logic [SEL_W-1:0] cur;
    logic             step;
    string            tag;
  } exp_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  string phase = "reset";

  // Reference model: channel index and cycles spent on it so far.
  int m_cur = 0;
  int m_cnt = 0;

  function automatic int next_chan(int from, logic [N-1:0] msk);
    for (int k = 1; k <= N; k++)
      if (msk[(from + k) % N]) return (from + k) % N;
    return from;
  endfunction

  function automatic logic [N-1:0] cold(int ch);
    logic [N-1:0] v;
    v = '1;
    v[ch] = 1'b0;
    return v;
  endfunction

  // Model the coming edge from the current inputs, queue it, advance one cycle.
  task automatic cyc();
    exp_t e;
    bit   enable;
    enable = en3 && !en1_n && !en2_n;
    e.qn = '1;
    e.step = 1'b0;
    e.tag = phase;
    if (rst) begin
      m_cur = 0;
      m_cnt = 0;
    end else if (!mode) begin
      m_cur = int'(sel);
      m_cnt = 0;
      if (enable) e.qn = cold(m_cur);
    end else if (enable && mask != 0) begin
      if (!mask[m_cur] || m_cnt >= int'(dwell)) begin
        m_cur = next_chan(m_cur, mask);
        m_cnt = 0;
        e.step = 1'b1;
      end else begin
        m_cnt++;
      end
      if (mask[m_cur]) e.qn = cold(m_cur);
    end
    e.cur = SEL_W'(m_cur);
    sbq.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        n_tests++;
        if (q_n !== e.qn || cur !== e.cur || step !== e.step) begin
          n_fail++;
          $display("FAIL %s: got q_n=%b cur=%0d step=%b, expected q_n=%b cur=%0d step=%b",
                   e.tag, q_n, cur, step, e.qn, e.cur, e.step);
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d expectations pending", sbq.size());
    $fatal(1, "timeout");
  end

  initial begin : driver
    rst = 1'b1; en1_n = 1'b0; en2_n = 1'b0; en3 = 1'b1; mode = 1'b0;
    sel = '0; dwell = '0; mask = '0;
    @(negedge clk);
    run(2);

    rst = 1'b0;
    phase = "manual_sweep";
    for (int s = 0; s < N; s++) begin
      sel = SEL_W'(s);
      cyc();
    end

    phase = "enable_gating";
    sel = 3'd5;
    en1_n = 1'b1; cyc(); en1_n = 1'b0;
    en2_n = 1'b1; cyc(); en2_n = 1'b0;
    en3 = 1'b0;   cyc(); en3 = 1'b1;
    cyc();

    phase = "scan_mask";
    sel = 3'd0; cyc();
    mode = 1'b1; mask = 8'b1010_0101; dwell = 16'd2;
    run(30);

    phase = "mask_zero";
    mask = '0;
    run(5);

    phase = "mask_clear_cur";
    mask = 8'hFF; dwell = 16'd5;
    run(2);
    mask = 8'hFF & ~(8'd1 << m_cur);
    run(4);

    phase = "single_bit";
    mask = 8'b0000_1000; dwell = 16'd1;
    run(9);

    phase = "dwell_zero";
    mask = 8'b0110_0011; dwell = 16'd0;
    run(8);

    phase = "enable_pause";
    mask = 8'hFF; dwell = 16'd3;
    for (int i = 0; i < 10 && m_cnt != 1; i++) cyc();
    en3 = 1'b0;
    run(5);
    en3 = 1'b1;
    run(6);

    phase = "dwell_shrink";
    dwell = 16'd6; run(4);
    dwell = 16'd1; run(4);

    phase = "reset_mid_scan";
    mask = 8'b1010_0101; dwell = 16'd2;
    for (int i = 0; i < 40 && m_cur != 5; i++) cyc();
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (q_n !== 8'hFF || cur !== 3'd0 || step !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got q_n=%b cur=%0d step=%b, expected q_n=11111111 cur=0 step=0",
               q_n, cur, step);
    end
    cyc();
    cyc();
    rst = 1'b0;
    phase = "after_reset";
    run(10);

    phase = "random";
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 59) == 0);
      mode  = ($urandom_range(0, 7) != 0);
      en1_n = ($urandom_range(0, 9) == 0);
      en2_n = ($urandom_range(0, 9) == 0);
      en3   = ($urandom_range(0, 9) != 0);
      sel   = SEL_W'($urandom_range(0, N - 1));
      if ($urandom_range(0, 7) == 0) dwell = DWELL_W'($urandom_range(0, 4));
      if ($urandom_range(0, 5) == 0) mask = N'($urandom_range(0, 255));
      cyc();
    end
    rst = 1'b0;

    repeat (3) @(posedge clk);
    #2;
    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations never checked, required 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
